// File: rtl/ram_dma_pkg.sv
// Shared types, sizes and the copy-length saturation rule for the RAM DMA sequencer.
package ram_dma_pkg;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int MAW   = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        DONE
    } state_t;

    // Requests longer than the RAM are clipped to one full pass.
    function automatic logic [AW:0] sat_len(input logic [AW:0] len);
        return (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    endfunction
endpackage

// File: rtl/ram_dma_addr_gen.sv
// Copy bookkeeping: latched bases and length, word counter, and wrapping source/destination addresses.
module ram_dma_addr_gen
    import ram_dma_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW:0]   len,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr,
    output logic          last
);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [AW-1:0] src_reg;
    logic [AW-1:0] dst_reg;
    logic [AW:0]   len_reg;
    logic [AW:0]   cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            src_reg <= src_base;
            dst_reg <= dst_base;
            len_reg <= len;
            cnt_reg <= '0;
        end else if (step) begin
            cnt_reg <= cnt_reg + ONE;
        end
    end

    // AW-bit sums wrap naturally modulo DEPTH.
    assign rd_addr = src_reg + cnt_reg[AW-1:0];
    assign wr_addr = dst_reg + cnt_reg[AW-1:0];
    assign last    = (cnt_reg + ONE) == len_reg;
endmodule

// File: rtl/ram_dma_ctrl.sv
// Block-copy sequencer and host pass-through arbiter; sole master of the single-port RAM pins.
module ram_dma_ctrl
    import ram_dma_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [AW-1:0]  src_addr,
    input  logic [AW-1:0]  dst_addr,
    input  logic [AW:0]    length,
    output logic           busy,
    output logic           done,
    input  logic           h_req,
    input  logic           h_wen,
    input  logic [AW-1:0]  h_addr,
    input  logic [DW-1:0]  h_wdata,
    output logic           h_gnt,
    output logic [DW-1:0]  h_rdata,
    output logic           m_cen,
    output logic           m_wen,
    output logic [MAW-1:0] m_addr,
    output logic [DW-1:0]  m_din,
    input  logic [DW-1:0]  m_dout
);
    state_t        state_reg;
    logic [DW-1:0] data_q_reg;
    logic [AW:0]   len_sat;
    logic          load;
    logic          last;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] word_addr;

    assign len_sat = sat_len(length);
    assign load    = (state_reg == IDLE) && start && (len_sat != '0);

    ram_dma_addr_gen u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .step     (state_reg == WRITE),
        .src_base (src_addr),
        .dst_base (dst_addr),
        .len      (len_sat),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .last     (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            data_q_reg <= '0;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_reg <= (len_sat != '0) ? READ : DONE;
                READ:    state_reg <= CAPT;
                CAPT: begin
                    data_q_reg <= m_dout;
                    state_reg  <= WRITE;
                end
                WRITE:   state_reg <= last ? DONE : READ;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = (state_reg == READ) || (state_reg == CAPT) || (state_reg == WRITE);
    assign done    = (state_reg == DONE);
    // Reset gates the host grant so the RAM pins stay quiet while reset_n is low.
    assign h_gnt   = reset_n && (state_reg == IDLE) && h_req;
    assign h_rdata = m_dout;

    always_comb begin
        m_cen     = 1'b0;
        m_wen     = 1'b0;
        word_addr = '0;
        m_din     = '0;
        case (state_reg)
            IDLE: if (h_gnt) begin
                m_cen     = 1'b1;
                m_wen     = h_wen;
                word_addr = h_addr;
                m_din     = h_wdata;
            end
            READ: begin
                m_cen     = 1'b1;
                word_addr = rd_addr;
            end
            WRITE: begin
                m_cen     = 1'b1;
                m_wen     = 1'b1;
                word_addr = wr_addr;
                m_din     = data_q_reg;
            end
            default: ;
        endcase
    end

    assign m_addr = {{(MAW-AW){1'b0}}, word_addr};
endmodule

// File: tb/tb_ram_dma_ctrl.sv
// Self-checking bench: behavioural RAM plus a word-array copy model of the expected memory contents.
module tb_ram_dma_ctrl;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  src_addr = '0;
    logic [5:0]  dst_addr = '0;
    logic [6:0]  length = '0;
    logic        busy, done;
    logic        h_req = 1'b0;
    logic        h_wen = 1'b0;
    logic [5:0]  h_addr = '0;
    logic [31:0] h_wdata = '0;
    logic        h_gnt;
    logic [31:0] h_rdata;
    logic        m_cen, m_wen;
    logic [15:0] m_addr;
    logic [31:0] m_din;
    logic [31:0] m_dout = '0;

    logic [31:0] ram  [DEPTH];
    logic [31:0] refm [DEPTH];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_dma_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .length(length), .busy(busy), .done(done),
        .h_req(h_req), .h_wen(h_wen), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rdata(h_rdata), .m_cen(m_cen), .m_wen(m_wen),
        .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
    );

    // 64x32 single-port RAM with registered read; dout reads 0 when not reading.
    always @(posedge clk) begin
        if (m_cen && m_wen) ram[m_addr[5:0]] <= m_din;
        m_dout <= (m_cen && !m_wen) ? ram[m_addr[5:0]] : 32'h0;
    end

    task automatic host_write(input int a, input logic [31:0] d);
        h_req = 1'b1; h_wen = 1'b1; h_addr = 6'(a); h_wdata = d;
        @(negedge clk);
        n_cmp++;
        if (h_gnt !== 1'b1 || m_cen !== 1'b1 || m_wen !== 1'b1 || m_addr !== 16'(a) || m_din !== d) begin
            n_fail++;
            $display("FAIL host_write a=%0d: gnt=%b cen=%b wen=%b addr=%0d din=%h, required 1 1 1 %0d %h",
                     a, h_gnt, m_cen, m_wen, m_addr, m_din, a, d);
        end
        refm[a] = d;
        @(posedge clk); #1;
        h_req = 1'b0;
    endtask

    task automatic host_read(input int a, input string tag);
        h_req = 1'b1; h_wen = 1'b0; h_addr = 6'(a);
        @(negedge clk);
        n_cmp++;
        if (h_gnt !== 1'b1 || m_cen !== 1'b1 || m_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL %s read_gnt a=%0d: gnt=%b cen=%b wen=%b, required 1 1 0", tag, a, h_gnt, m_cen, m_wen);
        end
        @(posedge clk); #1;
        h_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (h_rdata !== refm[a]) begin
            n_fail++;
            $display("FAIL %s read_data a=%0d: got %h, required %h", tag, a, h_rdata, refm[a]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 6; c++) begin
            start = 1'($urandom); h_req = 1'($urandom); h_wen = 1'($urandom);
            h_addr = 6'($urandom); h_wdata = $urandom; src_addr = 6'($urandom);
            dst_addr = 6'($urandom); length = 7'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({busy, done, h_gnt, m_cen, m_wen} !== 5'b0 || m_addr !== 16'h0 || m_din !== 32'h0 || h_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d: flags=%b addr=%h din=%h rdata=%h, required all 0",
                         c, {busy, done, h_gnt, m_cen, m_wen}, m_addr, m_din, h_rdata);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b1; start = 1'b0; h_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, h_gnt, m_cen} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy/done/gnt/cen=%b, required 0000", {busy, done, h_gnt, m_cen});
        end
        @(posedge clk); #1;
        $display("reset: held 6 cycles, released to idle");
    endtask

    task automatic test_host();
        host_write(3, 32'hDEADBEEF);
        host_read(3, "host");
        $display("host: write/read addr 3 data %h", refm[3]);
    endtask

    // Expected bus schedule: word i occupies cycles 3i+1..3i+3 (read, capture, write), done at 3N+1.
    task automatic run_copy(input int src, input int dst, input int len,
                            input bit hreq_mid, input bit start_mid, input bit host_at_start);
        int n, i, ph, hw_a, done_at;
        logic [31:0] hw_d, exp_din;
        logic exp_busy, exp_done, exp_cen, exp_wen;
        int exp_addr;
        n = (len > DEPTH) ? DEPTH : len;
        hw_a = $urandom_range(0, 63); hw_d = $urandom;
        start = 1'b1; src_addr = 6'(src); dst_addr = 6'(dst); length = 7'(len);
        if (host_at_start) begin
            h_req = 1'b1; h_wen = 1'b1; h_addr = 6'(hw_a); h_wdata = hw_d;
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || h_gnt !== host_at_start) begin
            n_fail++;
            $display("FAIL copy_start: busy=%b gnt=%b, required 0 %b", busy, h_gnt, host_at_start);
        end
        if (host_at_start) refm[hw_a] = hw_d;
        @(posedge clk); #1;
        start = 1'b0; h_req = 1'b0;
        if (hreq_mid) begin h_req = 1'b1; h_wen = 1'b0; h_addr = 6'(src); end
        done_at = -1;
        for (int k = 1; k <= 3*n + 1; k++) begin
            if (start_mid && k >= 2) begin
                start = 1'b1; src_addr = 6'($urandom); dst_addr = 6'($urandom); length = 7'd5;
            end
            @(negedge clk);
            if (done === 1'b1 && done_at < 0) done_at = k;
            exp_cen = 1'b0; exp_wen = 1'b0; exp_addr = 0; exp_din = '0;
            if (k <= 3*n) begin
                exp_busy = 1'b1; exp_done = 1'b0;
                i = (k - 1) / 3; ph = (k - 1) % 3;
                if (ph == 0) begin exp_cen = 1'b1; exp_addr = (src + i) % DEPTH; end
                if (ph == 2) begin
                    exp_cen = 1'b1; exp_wen = 1'b1; exp_addr = (dst + i) % DEPTH;
                    exp_din = refm[(src + i) % DEPTH];
                end
            end else begin
                exp_busy = 1'b0; exp_done = 1'b1;
            end
            n_cmp++;
            if ({busy, done, h_gnt, m_cen, m_wen} !== {exp_busy, exp_done, 1'b0, exp_cen, exp_wen}) begin
                n_fail++;
                $display("FAIL copy_flags k=%0d: busy/done/gnt/cen/wen=%b, required %b", k,
                         {busy, done, h_gnt, m_cen, m_wen}, {exp_busy, exp_done, 1'b0, exp_cen, exp_wen});
            end
            if (exp_cen) begin
                n_cmp++;
                if (m_addr !== 16'(exp_addr)) begin
                    n_fail++;
                    $display("FAIL copy_addr k=%0d: got %0d, required %0d", k, m_addr, exp_addr);
                end
            end
            if (exp_wen) begin
                n_cmp++;
                if (m_din !== exp_din) begin
                    n_fail++;
                    $display("FAIL copy_din k=%0d: got %h, required %h", k, m_din, exp_din);
                end
                refm[exp_addr] = exp_din;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, h_gnt, m_cen} !== {1'b0, 1'b0, hreq_mid, hreq_mid}) begin
            n_fail++;
            $display("FAIL copy_idle: busy/done/gnt/cen=%b, required %b", {busy, done, h_gnt, m_cen},
                     {1'b0, 1'b0, hreq_mid, hreq_mid});
        end
        @(posedge clk); #1;
        h_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || (hreq_mid && h_rdata !== refm[src])) begin
            n_fail++;
            $display("FAIL copy_after: busy=%b rdata=%h, required 0 %h", busy, h_rdata, refm[src]);
        end
        @(posedge clk); #1;
        $display("copy src=%0d dst=%0d len=%0d: done at cycle %0d (hreq=%0b start_mid=%0b host_start=%0b)",
                 src, dst, len, done_at, hreq_mid, start_mid, host_at_start);
    endtask

    task automatic test_basic_copy();
        host_write(0, 32'h11); host_write(1, 32'h22); host_write(2, 32'h33); host_write(3, 32'h44);
        run_copy(0, 16, 4, 1'b0, 1'b0, 1'b0);
        for (int a = 16; a < 20; a++) host_read(a, "basic");
    endtask

    task automatic test_wrap();
        run_copy(62, 10, 4, 1'b0, 1'b0, 1'b0);
        for (int a = 10; a < 14; a++) host_read(a, "wrap");
    endtask

    task automatic test_corner();
        run_copy(5, 9, 0, 1'b0, 1'b0, 1'b0);
        run_copy(7, 30, 3, 1'b0, 1'b1, 1'b0);
        run_copy(30, 50, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midcopy();
        start = 1'b1; src_addr = 6'd20; dst_addr = 6'd40; length = 7'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 9; k++) begin @(posedge clk); #1; end
        n_cmp++;
        if (m_cen !== 1'b1 || m_wen !== 1'b1 || m_addr !== 16'd42) begin
            n_fail++;
            $display("FAIL midrst_write: cen=%b wen=%b addr=%0d, required 1 1 42", m_cen, m_wen, m_addr);
        end
        reset_n = 1'b0; #1;
        n_cmp++;
        if ({busy, done, h_gnt, m_cen, m_wen} !== 5'b0 || m_addr !== 16'h0 || m_din !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: flags=%b addr=%h din=%h, required 0", {busy, done, h_gnt, m_cen, m_wen}, m_addr, m_din);
        end
        for (int i = 0; i < 2; i++) refm[40 + i] = refm[20 + i];
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_nodone c=%0d: busy=%b done=%b, required 0 0", c, busy, done);
            end
            @(posedge clk); #1;
        end
        for (int a = 40; a < 48; a++) host_read(a, "midrst");
        $display("midrst: copy 20->40 len 8 aborted in write of word 2");
    endtask

    task automatic test_random();
        for (int a = 0; a < DEPTH; a++) host_write(a, $urandom);
        for (int t = 0; t < 10; t++)
            run_copy($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 90),
                     1'($urandom), 1'($urandom), 1'($urandom));
        for (int a = 0; a < DEPTH; a++) host_read(a, "random");
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin ram[a] = 32'h0; refm[a] = 32'h0; end
        #1;
        test_reset();
        test_host();
        test_basic_copy();
        test_wrap();
        test_corner();
        test_reset_midcopy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_dma_ctrl.md
Name: ram_dma_ctrl

Overview:
Sequencer and arbiter in front of the 64x32 single-port RAM. Performs block copies (src -> dst, ascending, word by word) on a start pulse. Also passes single-cycle host reads and writes through to the RAM whenever no copy is running. It is the only master that drives the RAM's cen/wen/addr/din pins.

Parameters:
DEPTH, 64, RAM words
AW, 6, internal word-address width (log2 DEPTH)
DW, 32, data width
MAW, 16, RAM address port width; upper MAW-AW bits are driven 0

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  copy request, sampled in IDLE only
src_addr  in  AW  copy source base word address
dst_addr  in  AW  copy destination base word address
length  in  AW+1  words to copy; 0 = no-op; values >64 saturate to 64
busy  out  1  copy in progress
done  out  1  one-cycle pulse at copy completion
h_req  in  1  host access request
h_wen  in  1  host access type: 1 = write, 0 = read
h_addr  in  AW  host word address
h_wdata  in  DW  host write data
h_gnt  out  1  host access performed this cycle
h_rdata  out  DW  equals m_dout; valid only in the cycle after a granted read
m_cen  out  1  RAM chip enable (1 = active)
m_wen  out  1  RAM write enable (1 = write, 0 = read)
m_addr  out  MAW  RAM address, {zeros, word address}
m_din  out  DW  RAM write data
m_dout  in  DW  RAM read data; registered, valid one cycle after a read is issued

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, h_gnt, m_cen, m_wen = 0; m_addr, m_din = 0; internal regs (src/dst/len/cnt/data_q) = 0.
- FSM states: IDLE, READ, CAPT, WRITE, DONE.
- IDLE, start=1, saturated length != 0:
  - latch src, dst, len; set cnt=0; go to READ.
- IDLE, start=1, length == 0:
  - go to DONE.
  - no RAM access is made.
- IDLE, start=0: stay.
- READ:
  - m_cen=1, m_wen=0, m_addr = (src+cnt) mod 64.
  - go to CAPT.
- CAPT:
  - m_cen=0; data_q <= m_dout.
  - go to WRITE.
- WRITE:
  - m_cen=1, m_wen=1, m_addr = (dst+cnt) mod 64, m_din = data_q; cnt <= cnt+1.
  - if cnt+1 == len, go to DONE; else go to READ.
- DONE:
  - done=1 for exactly this cycle; go to IDLE.
- busy = 1 in READ, CAPT and WRITE only.
- Latency: a copy of N words occupies 3N busy cycles. done is asserted in cycle 3N+1 after the start edge. With N=0, done is asserted in the cycle right after start.
- Address arithmetic wraps modulo DEPTH. Overlapping regions use forward-copy semantics: a word written earlier may be re-read later in the same copy.
- start while busy or in DONE: ignored, not queued.
- Host path, IDLE state only, h_req=1:
  - combinationally m_cen=1, m_wen=h_wen, m_addr={0,h_addr}, m_din=h_wdata, h_gnt=1.
- Host path, all other states: h_gnt=0. The host must hold h_req until it sees h_gnt.
- start and h_req together in IDLE: the host access is granted that cycle and the copy starts next cycle (READ). There is no conflict.
- IDLE with no h_req: m_cen=0 (RAM dout then reads 0).
- Mid-copy reset: immediate return to IDLE. Destination is left partially written; no done pulse.

Decomposition:
- Package ram_dma_pkg holds:
  - state enum (IDLE, READ, CAPT, WRITE, DONE);
  - DEPTH, AW, DW, MAW constants;
  - the length-saturation function.
- Sub-module ram_dma_addr_gen: registered cnt plus modulo-DEPTH src/dst address adders.
- RAM-port mux and FSM stay in the top.

Test Plan:
1. Hold reset_n=0 with random inputs -> all outputs 0. Release -> IDLE, m_cen=0.
2. Host write h_addr=3, h_wdata=0xDEADBEEF, then host read addr 3 -> h_gnt=1 each request cycle; h_rdata=0xDEADBEEF in the cycle after the read grant.
3. Preload mem[0..3]=0x11,0x22,0x33,0x44; start src=0 dst=16 len=4 -> busy high 12 cycles, done pulse in cycle 13, mem[16..19] = 0x11..0x44.
4. Wrap case: src=62 dst=10 len=4 -> m_addr read sequence 62,63,0,1; write sequence 10..13.
5. start with len=0 -> done next cycle, m_cen stays 0. start while busy -> ignored. h_req raised mid-copy -> h_gnt=0 until the copy ends, then granted in the first IDLE cycle.
6. Pulse reset_n low during the WRITE of word 2 of a len=8 copy -> outputs 0 at once, no done pulse. mem[dst+2..dst+7] are unchanged.
